// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver: FSM state encoding and
// parity mode constants.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock ring-buffer FIFO. The head word is presented combinationally
// and reads as zero while the FIFO is empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array has no reset; stale words are unreachable because
   // rdata is masked while empty, and that keeps the array in plain RAM cells.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with configurable frame format, start-bit glitch rejection,
// parity/framing checks and a receive FIFO with overrun detection.
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx,
   output logic [DATA_BITS-1:0]        m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic                        frame_err,
   output logic                        parity_err,
   output logic                        overrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] HALF_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] FULL_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

   rx_state_t            state, next_state;
   logic                 rx_meta, rx_s;
   logic [CW-1:0]        clk_count;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err_q, stop_bad;
   logic                 half_tick, tick;
   logic                 frame_end, frame_bad, par_hit, frame_good;
   logic                 fifo_full, fifo_empty, pop;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, making the two synchronizer stages distinct.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign half_tick = (clk_count == HALF_CNT);
   assign tick      = (clk_count == FULL_CNT);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // NOTE: every output of this block is defaulted first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      frame_end  = 1'b0;
      case (state)
         ST_IDLE:      if (!rx_s) next_state = ST_START;
         ST_START:     if (half_tick) next_state = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:      if (tick && bit_idx == LAST_DATA)
                          next_state = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY:    if (tick) next_state = ST_STOP;
         ST_STOP: begin
            if (tick && bit_idx == LAST_STOP) begin
               frame_end  = 1'b1;
               next_state = (stop_bad || !rx_s) ? ST_WAIT_HIGH : ST_IDLE;
            end
         end
         ST_WAIT_HIGH: if (rx_s) next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_count <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_err_q <= 1'b0;
         stop_bad  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               clk_count <= '0;
               bit_idx   <= '0;
               par_err_q <= 1'b0;
               stop_bad  <= 1'b0;
            end
            ST_START: clk_count <= half_tick ? '0 : clk_count + 1'b1;
            ST_DATA, ST_PARITY, ST_STOP: begin
               if (tick) begin
                  clk_count <= '0;
                  if (state == ST_DATA) begin
                     shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                     bit_idx <= (bit_idx == LAST_DATA) ? '0 : bit_idx + 1'b1;
                  end else if (state == ST_PARITY) begin
                     par_err_q <= ((^shreg) ^ rx_s) != (PARITY == PAR_ODD);
                  end else begin
                     if (!rx_s) stop_bad <= 1'b1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  clk_count <= clk_count + 1'b1;
               end
            end
            default: clk_count <= '0;
         endcase
      end
   end

   // Framing error outranks parity error; only a clean frame reaches the FIFO.
   assign frame_bad  = frame_end && (stop_bad || !rx_s);
   assign par_hit    = frame_end && !frame_bad && par_err_q;
   assign frame_good = frame_end && !frame_bad && !par_err_q;
   assign pop        = m_valid && m_ready;
   assign m_valid    = !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= frame_bad;
         parity_err <= par_hit;
         overrun    <= frame_good && fifo_full && !pop;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (frame_good),
      .wdata (shreg),
      .pop   (pop),
      .rdata (m_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: four instances (8N1, even parity, two stop
// bits, nine data bits), all at 16 clocks per bit.
module tb_uart_rx_ext;
   import uart_pkg::*;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] rx = 4'hF;
   logic [3:0] m_ready = 4'h0;
   logic [3:0] m_valid, frame_err, parity_err, overrun;
   logic [7:0] md0, md1, md2;
   logic [8:0] md3;
   logic [2:0] fc0, fc1, fc2, fc3;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid [4];
   int n_ferr  [4];
   int n_perr  [4];
   int n_ovr   [4];
   int n_data0 = 0;
   logic [8:0] last_data [4];

   always #5 clk = ~clk;

   uart_rx_ext #(.CLKS_PER_BIT(CPB)) u0 (
      .clk(clk), .rst(rst), .rx(rx[0]), .m_data(md0), .m_valid(m_valid[0]),
      .m_ready(m_ready[0]), .frame_err(frame_err[0]), .parity_err(parity_err[0]),
      .overrun(overrun[0]), .fifo_count(fc0));

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN)) u1 (
      .clk(clk), .rst(rst), .rx(rx[1]), .m_data(md1), .m_valid(m_valid[1]),
      .m_ready(m_ready[1]), .frame_err(frame_err[1]), .parity_err(parity_err[1]),
      .overrun(overrun[1]), .fifo_count(fc1));

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u2 (
      .clk(clk), .rst(rst), .rx(rx[2]), .m_data(md2), .m_valid(m_valid[2]),
      .m_ready(m_ready[2]), .frame_err(frame_err[2]), .parity_err(parity_err[2]),
      .overrun(overrun[2]), .fifo_count(fc2));

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(9)) u3 (
      .clk(clk), .rst(rst), .rx(rx[3]), .m_data(md3), .m_valid(m_valid[3]),
      .m_ready(m_ready[3]), .frame_err(frame_err[3]), .parity_err(parity_err[3]),
      .overrun(overrun[3]), .fifo_count(fc3));

   // Cycle-level monitor: pulse/valid cycle counts and the last word popped.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (m_valid[i])    n_valid[i]++;
         if (frame_err[i])  n_ferr[i]++;
         if (parity_err[i]) n_perr[i]++;
         if (overrun[i])    n_ovr[i]++;
      end
      if (m_valid[0] && m_ready[0]) last_data[0] = {1'b0, md0};
      if (m_valid[1] && m_ready[1]) last_data[1] = {1'b0, md1};
      if (m_valid[2] && m_ready[2]) last_data[2] = {1'b0, md2};
      if (m_valid[3] && m_ready[3]) last_data[3] = md3;
      if (u0.state == ST_DATA) n_data0++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives n line bits LSB first, one bit period each; the last level is held.
   task automatic send_bits(input int ch, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rx[ch] = bits[i];
         tick(CPB);
      end
   endtask

   initial begin
      int v, e, f, p, o, d;

      // Reset state
      tick(4);
      rst = 1'b0;
      tick(2);
      check("rst_valid", {28'd0, m_valid}, 32'h0);
      check("rst_pulses", {20'd0, frame_err, parity_err, overrun}, 32'h0);
      check("rst_count0", {29'd0, fc0}, 32'h0);
      check("rst_data0", {24'd0, md0}, 32'h0);

      // 8N1, 0xA5 with consumer ready
      v = n_valid[0];
      e = n_ferr[0] + n_perr[0] + n_ovr[0];
      m_ready[0] = 1'b1;
      send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
      tick(16);
      check("a5_data", last_data[0], 9'h0A5);
      check("a5_valid_cycles", n_valid[0] - v, 1);
      check("a5_no_err", n_ferr[0] + n_perr[0] + n_ovr[0] - e, 0);

      // Three-cycle low glitch must not start a frame
      d = n_data0;
      v = n_valid[0];
      rx[0] = 1'b0;
      tick(3);
      rx[0] = 1'b1;
      tick(40);
      check("glitch_no_data_state", n_data0 - d, 0);
      check("glitch_no_valid", n_valid[0] - v, 0);
      check("glitch_no_err", n_ferr[0] + n_perr[0] + n_ovr[0] - e, 0);

      // Fill the FIFO with the consumer stalled, then overflow it
      m_ready[0] = 1'b0;
      o = n_ovr[0];
      for (int k = 1; k <= 4; k++) begin
         send_bits(0, {1'b1, 8'(k), 1'b0}, 10);
         tick(4);
      end
      check("fill4_count", {29'd0, fc0}, 32'd4);
      check("fill4_no_ovr", n_ovr[0] - o, 0);
      send_bits(0, {1'b1, 8'h05, 1'b0}, 10);
      tick(16);
      check("ovr_count", {29'd0, fc0}, 32'd4);
      check("ovr_pulse", n_ovr[0] - o, 1);
      check("ovr_head_stable", {24'd0, md0}, 32'h01);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("drain_%0d", k), {24'd0, md0}, 32'(k));
         m_ready[0] = 1'b1;
         tick(1);
         m_ready[0] = 1'b0;
      end
      check("drain_empty", {31'd0, m_valid[0]}, 32'd0);
      check("drain_count", {29'd0, fc0}, 32'd0);

      // Even parity: 0x07 has three ones, so a parity bit of 0 is wrong
      m_ready[1] = 1'b1;
      p = n_perr[1];
      v = n_valid[1];
      send_bits(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
      tick(16);
      check("par_bad_pulse", n_perr[1] - p, 1);
      check("par_bad_no_valid", n_valid[1] - v, 0);
      check("par_bad_no_ferr", n_ferr[1], 0);
      send_bits(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
      tick(16);
      check("par_ok_data", last_data[1], 9'h007);
      check("par_ok_valid", n_valid[1] - v, 1);
      check("par_ok_no_perr", n_perr[1] - p, 1);

      // Two stop bits, second one low, then the line stays low (break)
      m_ready[2] = 1'b1;
      f = n_ferr[2];
      v = n_valid[2];
      send_bits(2, {1'b0, 1'b1, 8'h3C, 1'b0}, 11);
      tick(64);
      check("stop2_ferr_once", n_ferr[2] - f, 1);
      check("stop2_wait_high", 32'(u2.state), 32'(ST_WAIT_HIGH));
      check("stop2_no_valid", n_valid[2] - v, 0);
      rx[2] = 1'b1;
      tick(8);
      check("stop2_back_idle", 32'(u2.state), 32'(ST_IDLE));
      tick(16);
      send_bits(2, {2'b11, 8'h3C, 1'b0}, 11);
      tick(16);
      check("stop2_good_data", last_data[2], 9'h03C);
      check("stop2_good_valid", n_valid[2] - v, 1);
      check("stop2_ferr_total", n_ferr[2] - f, 1);

      // Nine data bits
      m_ready[3] = 1'b1;
      v = n_valid[3];
      send_bits(3, {1'b1, 9'h1FF, 1'b0}, 11);
      tick(16);
      check("nine_data", last_data[3], 9'h1FF);
      check("nine_valid", n_valid[3] - v, 1);
      check("nine_no_err", n_ferr[3] + n_perr[3] + n_ovr[3], 0);

      // Reset in the middle of a frame with two words queued
      m_ready[0] = 1'b0;
      send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
      tick(4);
      send_bits(0, {1'b1, 8'h22, 1'b0}, 10);
      tick(4);
      check("pre_rst_count", {29'd0, fc0}, 32'd2);
      send_bits(0, 16'b1010, 4);
      check("pre_rst_in_data", 32'(u0.state), 32'(ST_DATA));
      rst = 1'b1;
      tick(1);
      check("mid_rst_valid", {31'd0, m_valid[0]}, 32'd0);
      check("mid_rst_count", {29'd0, fc0}, 32'd0);
      check("mid_rst_data", {24'd0, md0}, 32'd0);
      rst = 1'b0;
      tick(32);
      e = n_ferr[0] + n_perr[0] + n_ovr[0];
      v = n_valid[0];
      m_ready[0] = 1'b1;
      send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
      tick(16);
      check("post_rst_data", last_data[0], 9'h05A);
      check("post_rst_valid", n_valid[0] - v, 1);
      check("post_rst_count", {29'd0, fc0}, 32'd0);
      check("post_rst_no_err", n_ferr[0] + n_perr[0] + n_ovr[0] - e, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per bit period (range 8..4095).
REQ-002 The module SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (range 5..9).
REQ-003 The module SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 The module SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (1 or 2).
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-006 The module SHALL have port clk, input, 1, meaning the single clock.
REQ-007 The module SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-008 The module SHALL have port rx, input, 1, meaning the asynchronous serial line, idle high.
REQ-009 The module SHALL have port m_data, output, DATA_BITS, meaning the FIFO head word, LSB first on the line.
REQ-010 The module SHALL have port m_valid, output, 1, meaning the FIFO is non-empty.
REQ-011 The module SHALL have port m_ready, input, 1, meaning the consumer accepts m_data.
REQ-012 The module SHALL have port frame_err, output, 1, meaning a one-cycle pulse on a bad stop bit.
REQ-013 The module SHALL have port parity_err, output, 1, meaning a one-cycle pulse on a parity mismatch.
REQ-014 The module SHALL have port overrun, output, 1, meaning a one-cycle pulse when a good frame is dropped because the FIFO is full.
REQ-015 The module SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning the current occupancy.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; the synchronized value is rx_s; all sampling SHALL use rx_s.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-018 IDLE: on rx_s==0, the FSM SHALL go to START and clear the bit counter.
REQ-019 START: at clk_count==(CLKS_PER_BIT-1)/2, if rx_s==0 the FSM SHALL go to DATA with clk_count=0; otherwise it SHALL return to IDLE (glitch rejection).
REQ-020 DATA: at each clk_count==CLKS_PER_BIT-1, rx_s SHALL be shifted into bit[idx]; after DATA_BITS samples the FSM SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-021 PARITY: the FSM SHALL sample one bit; the error condition is (XOR of data bits XOR sampled bit) != (PARITY==2).
REQ-022 STOP: the FSM SHALL sample STOP_BITS bits at CLKS_PER_BIT spacing; any zero sample sets the framing error.
REQ-023 Frame end is the cycle of the final stop-bit sample; at frame end, at most one of these SHALL occur: framing error → frame_err=1, frame discarded, go to WAIT_HIGH; parity error (stop ok) → parity_err=1, frame discarded, go to IDLE; otherwise write to FIFO (or overrun if full and no simultaneous pop), go to IDLE.
REQ-024 WAIT_HIGH: the FSM SHALL remain until rx_s==1, then go to IDLE (break/stuck-low produces exactly one frame_err).
REQ-025 FIFO: a write at frame end SHALL make m_valid=1 on the next cycle when the FIFO was empty; a pop occurs when m_valid && m_ready.
REQ-026 On simultaneous pop and write with the FIFO full, the write SHALL be accepted, the count SHALL be unchanged, and no overrun SHALL occur.
REQ-027 On simultaneous pop and write otherwise, the count SHALL be unchanged.
REQ-028 m_data SHALL hold stable while m_valid && !m_ready.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH nor underflow (a pop when empty is impossible by m_valid).
REQ-030 Error/overrun pulses SHALL be exactly one cycle and mutually exclusive per frame.

Reset
REQ-031 On rst=1 at a clk edge: the FSM SHALL go to IDLE; counters and pointers SHALL be 0; fifo_count=0; m_valid=0; frame_err=parity_err=overrun=0; the synchronizer flops SHALL be 1; m_data SHALL be 0.
REQ-032 Reset mid-frame or mid-FIFO SHALL discard all partial and stored data; the first start bit detected after rst deasserts SHALL begin a fresh frame.

Structure
REQ-033 The FSM state encoding and the PARITY mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) SHALL live in shared package uart_pkg.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count).
REQ-035 The clk_count width SHALL be $clog2(CLKS_PER_BIT)+1.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-036 The bench SHALL cover: defaults 8N1, send 0xA5, m_ready=1 → m_data=0xA5, m_valid for 1 cycle, no error pulses.
REQ-037 The bench SHALL cover: PARITY=1, send 0x07 with parity bit 0 → parity_err pulse, m_valid stays 0; resend with parity 1 → m_data=0x07.
REQ-038 The bench SHALL cover: STOP_BITS=2, second stop bit driven 0 → frame_err pulse once, FSM in WAIT_HIGH until rx=1, then 0x3C received correctly.
REQ-039 The bench SHALL cover: FIFO_DEPTH=4, m_ready=0, send 5 bytes 0x01..0x05 → fifo_count=4, overrun pulse on 5th; drain → 0x01,0x02,0x03,0x04.
REQ-040 The bench SHALL cover: a rx low glitch of 3 cycles → no START→DATA transition, no output; DATA_BITS=9, send 0x1FF → m_data=9'h1FF.
REQ-041 The bench SHALL cover: rst asserted mid-DATA with 2 entries queued → m_valid=0, fifo_count=0 next cycle; the next byte 0x5A is received intact.
